// File: rtl/muldiv_pkg.sv
// Shared types and ALU encodings for the sequential multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    ZDIV = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared add/sub ALU,
// performing one shift-add or restoring-divide iteration per granted cycle.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// RUN   | one iteration per cycle with alu_gnt=1; holds otherwise
// ZDIV  | divide by zero; result fixed without ALU use
// DONE  | result valid, done pulses, then back to IDLE
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_t          state;
  op_t             op_q;
  logic [CW-1:0]   count;
  // hi/lo double as rem/q for divide; m holds the multiplicand or divisor
  logic [WIDTH-1:0] hi, lo, m;

  logic             is_div;
  logic [WIDTH-1:0] s, srca, srcb, hi_nx, lo_nx, res_sel;
  logic [2:0]       control;
  logic             c, brw, ok;

  always_comb begin
    is_div  = (op_q == OP_DIVU) || (op_q == OP_REMU);
    s       = {hi[WIDTH-2:0], lo[WIDTH-1]};
    srca    = '0;
    srcb    = '0;
    control = ALU_ADD;
    if (state == RUN) begin
      if (is_div) begin
        srca    = s;
        srcb    = m;
        control = ALU_SUB;
      end else begin
        srca = hi;
        srcb = lo[0] ? m : '0;
      end
    end
    // carry out of hi+srcb and borrow out of s-d, rebuilt from the ALU's 32-bit result
    c   = (hi[WIDTH-1] & srcb[WIDTH-1]) |
          ((hi[WIDTH-1] | srcb[WIDTH-1]) & ~alu_result[WIDTH-1]);
    brw = (~s[WIDTH-1] & m[WIDTH-1]) |
          (~(s[WIDTH-1] ^ m[WIDTH-1]) & alu_result[WIDTH-1]);
    ok  = hi[WIDTH-1] | ~brw;
    if (is_div) begin
      hi_nx = ok ? alu_result : s;
      lo_nx = {lo[WIDTH-2:0], ok};
    end else begin
      hi_nx = {c, alu_result[WIDTH-1:1]};
      lo_nx = {alu_result[0], lo[WIDTH-1:1]};
    end
    res_sel = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? hi_nx : lo_nx;
  end

  assign alu_req     = (state == RUN);
  assign alu_srca    = srca;
  assign alu_srcb    = srcb;
  assign alu_control = control;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= OP_MUL;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op_t'(op);
            count <= '0;
            busy  <= 1'b1;
            hi    <= '0;
            if (op[1]) begin
              lo    <= a;
              m     <= b;
              state <= (b == '0) ? ZDIV : RUN;
            end else begin
              lo    <= b;
              m     <= a;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (alu_gnt) begin
            hi    <= hi_nx;
            lo    <= lo_nx;
            count <= count + 1'b1;
            if (count == LAST) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= res_sel;
            end
          end
        end
        ZDIV: begin
          state  <= DONE;
          done   <= 1'b1;
          result <= (op_q == OP_DIVU) ? '1 : lo;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed ops push expected result/latency, a monitor
// compares whenever done pulses; the ALU is modelled here as a plain add/sub.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, alu_req, alu_gnt;
  logic [31:0] result, alu_srca, alu_srcb, alu_result;
  logic [2:0]  alu_control;

  muldiv_seq #(.WIDTH(32), .ITERS(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_control(alu_control), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit gnt_toggle = 1'b0;
  int t_acc = 0;
  assign alu_gnt    = !gnt_toggle || (((cyc - t_acc) % 2) == 0);
  assign alu_result = (alu_control == ALU_SUB) ? alu_srca - alu_srcb : alu_srca + alu_srcb;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
    string       name;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no pending op", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, " result"}, result, e.res);
        chk({e.name, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] er, input int lat,
                        input bit tog, input bit midstart, input int exp_req);
    int  req_cnt;
    bit  seen;
    exp_t x;
    req_cnt = 0;
    seen    = 1'b0;
    @(negedge clk);
    gnt_toggle = tog;
    t_acc      = cyc;
    start = 1'b1; op = o; a = av; b = bv;
    x.res = er; x.lat = lat; x.t0 = cyc; x.name = name;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    chk({name, " busy_after_accept"}, 32'(busy), 32'd1);
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (alu_req) req_cnt++;
      start = midstart && (i == 10);
      if (start) begin op = OP_DIVU; a = 32'd1; b = 32'd0; end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: got no done within 200 cycles want done", name);
    end
    chk({name, " alu_req_cycles"}, 32'(req_cnt), 32'(exp_req));
    chk({name, " busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({name, " busy_after_done"}, 32'(busy), 32'd0);
    chk({name, " done_single"}, 32'(done), 32'd0);
    gnt_toggle = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset alu_req", 32'(alu_req), 32'd0);
    chk("reset srca", alu_srca, 32'd0);
    chk("reset srcb", alu_srcb, 32'd0);
    chk("reset control", 32'(alu_control), 32'(ALU_ADD));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op("mul_7x6",       OP_MUL,   32'd7,         32'd6,         32'd42,        33, 1'b0, 1'b0, 32);
    run_op("mulhu_ffxff",   OP_MULHU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  33, 1'b0, 1'b0, 32);
    run_op("mul_ffxff",     OP_MUL,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  33, 1'b0, 1'b0, 32);
    run_op("mulhu_shift4",  OP_MULHU, 32'h12345678,  32'h00000010,  32'h00000001,  33, 1'b0, 1'b0, 32);
    run_op("divu_100_7",    OP_DIVU,  32'd100,       32'd7,         32'd14,        33, 1'b0, 1'b0, 32);
    run_op("remu_100_7",    OP_REMU,  32'd100,       32'd7,         32'd2,         33, 1'b0, 1'b0, 32);
    run_op("divu_max_msb",  OP_DIVU,  32'hFFFFFFFF,  32'h80000000,  32'd1,         33, 1'b0, 1'b0, 32);
    run_op("divu_5_0",      OP_DIVU,  32'd5,         32'd0,         32'hFFFFFFFF,  2,  1'b0, 1'b0, 0);
    run_op("remu_5_0",      OP_REMU,  32'd5,         32'd0,         32'd5,         2,  1'b0, 1'b0, 0);
    run_op("mul_7x6_gnt",   OP_MUL,   32'd7,         32'd6,         32'd42,        65, 1'b1, 1'b1, 64);

    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort alu_req", 32'(alu_req), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("divu_9_3",      OP_DIVU,  32'd9,         32'd3,         32'd3,         33, 1'b0, 1'b0, 32);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
